decode_regfile_stage: RTL and testbench

- Parametrised decode stage for the 5-stage MIPS pipeline; sits between the IF/ID register and EX.
- Contains the general register file with 1 or 2 write-back ports and W-stage write-through bypass.
- Selects operands from external forwarding, resolves branches and jumps in the same cycle, and drives the ID/EX pipeline register with stall-bubble and flush support.

---
 rtl/decode_regfile_stage.sv | 203 ++++++++++++++++++++
 tb/tb_decode_regfile_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/decode_regfile_stage.sv
// decode_regfile_stage: MIPS decode stage.
// - General register file with 1 or 2 write-back ports, plus W-stage write-through bypass.
// - Operand select from external forwarding, bypass or the array.
// - Same-cycle branch/jump resolution.
// - ID/EX pipeline register with stall-bubble and flush.
// Optional feature macro: DECODE_BRANCH_EXT_EN enables bne/blez/bgtz/bltz/bgez redirects.
module decode_regfile_stage #(
  parameter int REG_NUM  = 32,
  parameter int WB_PORTS = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  stall,
  input  logic                                  flush,
  input  logic [31:0]                           id_pc,
  input  logic [31:0]                           id_instr,
  input  logic [WB_PORTS-1:0]                   wb_we,
  input  logic [WB_PORTS*$clog2(REG_NUM)-1:0]   wb_addr,
  input  logic [WB_PORTS*32-1:0]                wb_data,
  input  logic [2:0]                            rs_fwd_sel,
  input  logic [31:0]                           rs_fwd_data,
  input  logic [2:0]                            rt_fwd_sel,
  input  logic [31:0]                           rt_fwd_data,
  output logic [2:0]                            redirect_kind,
  output logic [31:0]                           redirect_pc,
  output logic [31:0]                           ex_rs,
  output logic [31:0]                           ex_rt,
  output logic [31:0]                           ex_instr,
  output logic [31:0]                           ex_pc,
  output logic                                  ex_valid
);

  localparam int ADDR_W = $clog2(REG_NUM);

  logic [31:0]       r_regs [REG_NUM];
  logic [ADDR_W-1:0] w_rs_a;
  logic [ADDR_W-1:0] w_rt_a;
  logic [31:0]       w_rs_byp;
  logic [31:0]       w_rt_byp;
  logic [31:0]       w_rs_use;
  logic [31:0]       w_rt_use;
  logic [5:0]        w_op;
  logic [5:0]        w_func;
  logic [4:0]        w_rt_field;
  logic [31:0]       w_pc4;
  logic [31:0]       w_br_tgt;
  logic [31:0]       w_j_tgt;
  logic [2:0]        w_kind;
  logic [31:0]       w_rpc;
  logic [31:0]       r_ex_rs;
  logic [31:0]       r_ex_rt;
  logic [31:0]       r_ex_instr;
  logic [31:0]       r_ex_pc;
  logic              r_ex_valid;

  // Only the low ADDR_W bits of the rs/rt fields address the register file.
  assign w_rs_a     = id_instr[21 +: ADDR_W];
  assign w_rt_a     = id_instr[16 +: ADDR_W];
  assign w_op       = id_instr[31:26];
  assign w_func     = id_instr[5:0];
  assign w_rt_field = id_instr[20:16];
  assign w_pc4      = id_pc + 32'd4;
  assign w_br_tgt   = w_pc4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
  assign w_j_tgt    = {id_pc[31:28], id_instr[25:0], 2'b00};

  // Register array.
  // - Reset clears every entry.
  // - Writes to $0 are dropped, so entry 0 always reads 0.
  // - A later port overwrites an earlier one on the same address, which gives port 1 priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs <= '{default: 32'd0};
    end else begin
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_we[k] && (wb_addr[k*ADDR_W +: ADDR_W] != {ADDR_W{1'b0}})) begin
          r_regs[wb_addr[k*ADDR_W +: ADDR_W]] <= wb_data[k*32 +: 32];
        end
      end
    end
  end

  // Write-through bypass over the array read.
  // - Ports are scanned in ascending order, so port 1 wins over port 0.
  // - A write aimed at $0 never bypasses.
  always_comb begin
    w_rs_byp = r_regs[w_rs_a];
    w_rt_byp = r_regs[w_rt_a];
    for (int k = 0; k < WB_PORTS; k++) begin
      w_rs_byp = (wb_we[k] && (wb_addr[k*ADDR_W +: ADDR_W] == w_rs_a) &&
                  (wb_addr[k*ADDR_W +: ADDR_W] != {ADDR_W{1'b0}})) ? wb_data[k*32 +: 32] : w_rs_byp;
      w_rt_byp = (wb_we[k] && (wb_addr[k*ADDR_W +: ADDR_W] == w_rt_a) &&
                  (wb_addr[k*ADDR_W +: ADDR_W] != {ADDR_W{1'b0}})) ? wb_data[k*32 +: 32] : w_rt_byp;
    end
  end

  // External forwarding takes precedence over the bypass and the array.
  assign w_rs_use = (rs_fwd_sel != 3'd0) ? rs_fwd_data : w_rs_byp;
  assign w_rt_use = (rt_fwd_sel != 3'd0) ? rt_fwd_data : w_rt_byp;

  // Same-cycle branch/jump resolution.
  // - Suppressed while the decode slot is reset, stalled or squashed.
  // - When no redirect is taken, redirect_pc is the fall-through address id_pc+4.
  always_comb begin
    w_kind = 3'd0;
    w_rpc  = w_pc4;
    if (rst || stall || flush) begin
      w_kind = 3'd0;
      w_rpc  = w_pc4;
    end else begin
      case (w_op)
        6'b000100: begin
          if (w_rs_use == w_rt_use) begin
            w_kind = 3'd1;
            w_rpc  = w_br_tgt;
          end else begin
            w_kind = 3'd0;
            w_rpc  = w_pc4;
          end
        end
`ifdef DECODE_BRANCH_EXT_EN
        6'b000101: begin
          w_kind = (w_rs_use != w_rt_use) ? 3'd1 : 3'd0;
          w_rpc  = (w_rs_use != w_rt_use) ? w_br_tgt : w_pc4;
        end
        6'b000110: begin
          w_kind = ($signed(w_rs_use) <= 32'sd0) ? 3'd1 : 3'd0;
          w_rpc  = ($signed(w_rs_use) <= 32'sd0) ? w_br_tgt : w_pc4;
        end
        6'b000111: begin
          w_kind = ($signed(w_rs_use) > 32'sd0) ? 3'd1 : 3'd0;
          w_rpc  = ($signed(w_rs_use) > 32'sd0) ? w_br_tgt : w_pc4;
        end
        6'b000001: begin
          case (w_rt_field)
            5'd0: begin
              w_kind = w_rs_use[31] ? 3'd1 : 3'd0;
              w_rpc  = w_rs_use[31] ? w_br_tgt : w_pc4;
            end
            5'd1: begin
              w_kind = w_rs_use[31] ? 3'd0 : 3'd1;
              w_rpc  = w_rs_use[31] ? w_pc4 : w_br_tgt;
            end
            default: begin
              w_kind = 3'd0;
              w_rpc  = w_pc4;
            end
          endcase
        end
`endif
        6'b000010, 6'b000011: begin
          w_kind = 3'd2;
          w_rpc  = w_j_tgt;
        end
        6'b000000: begin
          if ((w_func == 6'b001000) || (w_func == 6'b001001)) begin
            w_kind = 3'd3;
            w_rpc  = w_rs_use;
          end else begin
            w_kind = 3'd0;
            w_rpc  = w_pc4;
          end
        end
        default: begin
          w_kind = 3'd0;
          w_rpc  = w_pc4;
        end
      endcase
    end
  end

  assign redirect_kind = w_kind;
  assign redirect_pc   = w_rpc;

  // ID/EX register.
  // - Stall and flush both inject a bubble.
  // - During a bubble the operand registers keep their previous contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_rs    <= 32'd0;
      r_ex_rt    <= 32'd0;
      r_ex_instr <= 32'd0;
      r_ex_pc    <= 32'd0;
      r_ex_valid <= 1'b0;
    end else if (flush || stall) begin
      r_ex_instr <= 32'd0;
      r_ex_pc    <= 32'd0;
      r_ex_valid <= 1'b0;
    end else begin
      r_ex_rs    <= w_rs_use;
      r_ex_rt    <= w_rt_use;
      r_ex_instr <= id_instr;
      r_ex_pc    <= id_pc;
      r_ex_valid <= 1'b1;
    end
  end

  assign ex_rs    = r_ex_rs;
  assign ex_rt    = r_ex_rt;
  assign ex_instr = r_ex_instr;
  assign ex_pc    = r_ex_pc;
  assign ex_valid = r_ex_valid;

endmodule

// File: tb/tb_decode_regfile_stage.sv
// Directed testbench for decode_regfile_stage (REG_NUM=32, WB_PORTS=2).
// Redirect outputs are checked mid-cycle; ID/EX outputs are checked against a scoreboard queue after each edge.
module tb_decode_regfile_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [31:0] id_pc, id_instr;
  logic [1:0]  wb_we;
  logic [9:0]  wb_addr;
  logic [63:0] wb_data;
  logic [2:0]  rs_fwd_sel, rt_fwd_sel;
  logic [31:0] rs_fwd_data, rt_fwd_data;
  logic [2:0]  redirect_kind;
  logic [31:0] redirect_pc, ex_rs, ex_rt, ex_instr, ex_pc;
  logic        ex_valid;

  typedef struct {
    logic        valid;
    logic [31:0] rs, rt, instr, pc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_rs = 32'd0;
  logic [31:0] last_rt = 32'd0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  decode_regfile_stage #(.REG_NUM(32), .WB_PORTS(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_pc(id_pc), .id_instr(id_instr),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs_fwd_sel(rs_fwd_sel), .rs_fwd_data(rs_fwd_data),
    .rt_fwd_sel(rt_fwd_sel), .rt_fwd_data(rt_fwd_data),
    .redirect_kind(redirect_kind), .redirect_pc(redirect_pc),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_instr(ex_instr), .ex_pc(ex_pc), .ex_valid(ex_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, 5'd0, 5'd0, 6'h20};
  endfunction

  // Drive default (idle) values before each step.
  task automatic idle();
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    wb_we = 2'b00; wb_addr = 10'd0; wb_data = 64'd0;
    rs_fwd_sel = 3'd0; rs_fwd_data = 32'd0;
    rt_fwd_sel = 3'd0; rt_fwd_data = 32'd0;
  endtask

  task automatic push(input logic v, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.valid = v; e.rs = rs; e.rt = rt; e.instr = instr; e.pc = pc;
    sb_q.push_back(e);
    last_rs = rs;
    last_rt = rt;
  endtask

  task automatic bubble();
    push(1'b0, last_rs, last_rt, 32'd0, 32'd0);
  endtask

  task automatic tick(input string tag, input logic [2:0] kind, input logic [31:0] rpc, input bit chk_pc);
    exp_t e;
    #4;
    chk({tag, ".kind"}, {29'd0, redirect_kind}, {29'd0, kind});
    if (chk_pc) chk({tag, ".rpc"}, redirect_pc, rpc);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, e.valid});
      chk({tag, ".rs"}, ex_rs, e.rs);
      chk({tag, ".rt"}, ex_rt, e.rt);
      chk({tag, ".instr"}, ex_instr, e.instr);
      chk({tag, ".pc"}, ex_pc, e.pc);
    end
  endtask

  initial begin
    logic [31:0] ins;
    idle();
    rst = 1'b1; id_pc = 32'd0; id_instr = 32'd0;
    // Two reset cycles.
    push(1'b0, 32'd0, 32'd0, 32'd0, 32'd0); tick("rst0", 3'd0, 32'd0, 1'b0);
    rst = 1'b1;
    push(1'b0, 32'd0, 32'd0, 32'd0, 32'd0); tick("rst1", 3'd0, 32'd0, 1'b0);

    // First non-stalled decode after reset reads zeros.
    idle(); ins = rtype(5'd3, 5'd4); id_instr = ins; id_pc = 32'h100;
    push(1'b1, 32'd0, 32'd0, ins, 32'h100); tick("read0", 3'd0, 32'h104, 1'b1);

    // Write reg5 while reading it: bypass.
    idle(); ins = rtype(5'd5, 5'd0); id_instr = ins; id_pc = 32'h104;
    wb_we = 2'b01; wb_addr = {5'd0, 5'd5}; wb_data = {32'd0, 32'h1234};
    push(1'b1, 32'h1234, 32'd0, ins, 32'h104); tick("byp5", 3'd0, 32'h108, 1'b1);

    // Same read from the array.
    idle(); id_pc = 32'h108;
    push(1'b1, 32'h1234, 32'd0, ins, 32'h108); tick("arr5", 3'd0, 32'h10C, 1'b1);

    // Write to $0 is neither bypassed nor stored.
    idle(); ins = rtype(5'd0, 5'd0); id_instr = ins; id_pc = 32'h10C;
    wb_we = 2'b11; wb_addr = {5'd0, 5'd0}; wb_data = {32'hBEEF, 32'hDEAD};
    push(1'b1, 32'd0, 32'd0, ins, 32'h10C); tick("wr0byp", 3'd0, 32'h110, 1'b1);
    idle(); id_pc = 32'h110;
    push(1'b1, 32'd0, 32'd0, ins, 32'h110); tick("wr0arr", 3'd0, 32'h114, 1'b1);

    // Both ports write reg7: port 1 wins in bypass and array.
    idle(); ins = rtype(5'd7, 5'd5); id_instr = ins; id_pc = 32'h114;
    wb_we = 2'b11; wb_addr = {5'd7, 5'd7}; wb_data = {32'hBBBB, 32'hAAAA};
    push(1'b1, 32'hBBBB, 32'h1234, ins, 32'h114); tick("dual_byp", 3'd0, 32'h118, 1'b1);
    idle(); ins = rtype(5'd7, 5'd7); id_instr = ins; id_pc = 32'h118;
    push(1'b1, 32'hBBBB, 32'hBBBB, ins, 32'h118); tick("dual_arr", 3'd0, 32'h11C, 1'b1);

    // Distinct writes on both ports: reg2=9 (port0), reg31=0x3400 (port1).
    idle(); ins = rtype(5'd2, 5'd31); id_instr = ins; id_pc = 32'h11C;
    wb_we = 2'b11; wb_addr = {5'd31, 5'd2}; wb_data = {32'h3400, 32'd9};
    push(1'b1, 32'd9, 32'h3400, ins, 32'h11C); tick("two_wr", 3'd0, 32'h120, 1'b1);

    // beq $1,$2 with rs forwarded = 9, reg2 = 9: taken.
    idle(); ins = {6'b000100, 5'd1, 5'd2, 16'h0004}; id_instr = ins; id_pc = 32'h3000;
    rs_fwd_sel = 3'd1; rs_fwd_data = 32'd9;
    push(1'b1, 32'd9, 32'd9, ins, 32'h3000); tick("beq", 3'd1, 32'h3014, 1'b1);

    // Same with stall: no redirect, bubble, operands hold.
    stall = 1'b1; bubble(); tick("beq_stall", 3'd0, 32'h3004, 1'b1);

    // jr $31.
    idle(); ins = {6'd0, 5'd31, 5'd0, 5'd0, 5'd0, 6'b001000}; id_instr = ins; id_pc = 32'h3004;
    push(1'b1, 32'h3400, 32'd0, ins, 32'h3004); tick("jr", 3'd3, 32'h3400, 1'b1);

    // jal index 0x0C00.
    idle(); ins = {6'b000011, 26'h0000C00}; id_instr = ins; id_pc = 32'h3008;
    push(1'b1, 32'd0, 32'd0, ins, 32'h3008); tick("jal", 3'd2, 32'h00003000, 1'b1);

    // Flush: no redirect, bubble.
    flush = 1'b1; id_pc = 32'h300C; bubble(); tick("flush", 3'd0, 32'h3010, 1'b1);

    // bgtz with rs = -1: not taken in either build.
    idle(); ins = {6'b000111, 5'd1, 5'd0, 16'h0008}; id_instr = ins; id_pc = 32'h4000;
    rs_fwd_sel = 3'd4; rs_fwd_data = 32'hFFFF_FFFF;
    push(1'b1, 32'hFFFF_FFFF, 32'd0, ins, 32'h4000); tick("bgtz", 3'd0, 32'h4004, 1'b1);

    // bgez $0: taken only with the extension enabled.
    idle(); ins = {6'b000001, 5'd0, 5'd1, 16'h0008}; id_instr = ins; id_pc = 32'h4004;
    push(1'b1, 32'd0, 32'd0, ins, 32'h4004);
`ifdef DECODE_BRANCH_EXT_EN
    tick("bgez", 3'd1, 32'h4028, 1'b1);
`else
    tick("bgez", 3'd0, 32'h4008, 1'b1);
`endif

    // beq $7,$4 with rt forwarded = 0xBBBB, backward offset.
    idle(); ins = {6'b000100, 5'd7, 5'd4, 16'hFFFF}; id_instr = ins; id_pc = 32'h5000;
    rt_fwd_sel = 3'd2; rt_fwd_data = 32'hBBBB;
    push(1'b1, 32'hBBBB, 32'hBBBB, ins, 32'h5000); tick("beq_back", 3'd1, 32'h5000, 1'b1);

    // Reset clears the array and the ID/EX register.
    idle(); rst = 1'b1;
    push(1'b0, 32'd0, 32'd0, 32'd0, 32'd0); tick("rst2", 3'd0, 32'd0, 1'b0);
    idle(); ins = rtype(5'd7, 5'd31); id_instr = ins; id_pc = 32'h200;
    push(1'b1, 32'd0, 32'd0, ins, 32'h200); tick("post_rst", 3'd0, 32'h204, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
